// File: rtl/tlb_ctrl_pkg.sv
// Shared sizes, FSM encoding and permission helper for the TLB controller.
// FLUSH state exists only when TLB_FLUSH_EN is defined.
package tlb_ctrl_pkg;

  localparam int NUM_SETS         = 16;
  localparam int NUM_WAYS         = 4;
  localparam int SET_INDEX_BITS   = 4;
  localparam int LRU_BITS         = 4;
  localparam int WAY_BITS         = 2;
  localparam int VPN_BITS         = 20;
  localparam int PPN_BITS         = 20;
  localparam int PAGE_OFFSET_BITS = 12;
  localparam int PERM_R           = 0;
  localparam int PERM_W           = 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WALK_REQ  = 3'd2,
    S_WALK_WAIT = 3'd3,
    S_FILL      = 3'd4,
    S_RESP      = 3'd5
`ifdef TLB_FLUSH_EN
    ,S_FLUSH    = 3'd6
`endif
  } state_t;

  function automatic logic perm_ok(
    input logic [1:0] perms,
    input logic       write
  );
    return write ? perms[PERM_W] : perms[PERM_R];
  endfunction

endpackage

// File: rtl/tlb_victim_sel.sv
// Miss victim choice: lowest invalid way, else smallest use count
// (lowest index on ties).
module tlb_victim_sel
  import tlb_ctrl_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int LRU_BITS = 4
) (
  input  logic [NUM_WAYS-1:0]          valid,
  input  logic [LRU_BITS*NUM_WAYS-1:0] lru_count,
  output logic [WAY_BITS-1:0]          victim
);

  logic                inv_found;
  logic [WAY_BITS-1:0] inv_way;
  logic [WAY_BITS-1:0] min_way;
  logic [LRU_BITS-1:0] min_cnt;

  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    min_way   = '0;
    min_cnt   = lru_count[LRU_BITS-1:0];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(w);
      end
    end
    // strict compare keeps the earlier way on a tie
    for (int w = 1; w < NUM_WAYS; w++) begin
      if (lru_count[w*LRU_BITS +: LRU_BITS] < min_cnt) begin
        min_cnt = lru_count[w*LRU_BITS +: LRU_BITS];
        min_way = WAY_BITS'(w);
      end
    end
    victim = inv_found ? inv_way : min_way;
  end

endmodule

// File: rtl/tlb_ctrl.sv
// TLB lookup/fill controller in front of tlb_storage and the page walker.
// Define TLB_FLUSH_EN to add flush_req/flush_busy and the FLUSH sweep.
module tlb_ctrl
  import tlb_ctrl_pkg::*;
#(
  parameter int NUM_SETS       = 16,
  parameter int NUM_WAYS       = 4,
  parameter int SET_INDEX_BITS = 4,
  parameter int LRU_BITS       = 4
) (
  input  logic                           clk,
  input  logic                           rst,
`ifdef TLB_FLUSH_EN
  input  logic                           flush_req,
  output logic                           flush_busy,
`endif
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_vaddr,
  input  logic                           req_write,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [31:0]                    resp_paddr,
  output logic                           resp_hit,
  output logic                           resp_fault,
  output logic                           walk_req_valid,
  input  logic                           walk_req_ready,
  output logic [19:0]                    walk_vpn,
  input  logic                           walk_resp_valid,
  input  logic                           walk_fault,
  input  logic [19:0]                    walk_ppn,
  input  logic [1:0]                     walk_perms,
  output logic [SET_INDEX_BITS-1:0]      rd_set_index,
  input  logic [NUM_WAYS-1:0]            rd_valid,
  input  logic [2*NUM_WAYS-1:0]          rd_perms,
  input  logic [20*NUM_WAYS-1:0]         rd_vpn,
  input  logic [20*NUM_WAYS-1:0]         rd_ppn,
  input  logic [LRU_BITS*NUM_WAYS-1:0]   rd_lru_count,
  output logic                           wr_en,
  output logic [SET_INDEX_BITS-1:0]      wr_set_index,
  output logic [1:0]                     wr_way,
  output logic                           wr_valid,
  output logic [19:0]                    wr_vpn,
  output logic [19:0]                    wr_ppn,
  output logic [1:0]                     wr_perms,
  output logic [LRU_BITS-1:0]            wr_lru_count,
  output logic                           lru_update_en,
  output logic [SET_INDEX_BITS-1:0]      lru_set_index,
  output logic [1:0]                     lru_way,
  output logic [LRU_BITS-1:0]            lru_value
);

  state_t state, state_nxt;

  logic [31:0]         vaddr_q;
  logic                write_q;
  logic [19:0]         ppn_q;
  logic [1:0]          perms_q;
  logic                hit_q;
  logic                fault_q;
  logic [WAY_BITS-1:0] way_q;

  logic [VPN_BITS-1:0]       vpn;
  logic [SET_INDEX_BITS-1:0] set;

  logic                hit;
  logic [WAY_BITS-1:0] hit_way;
  logic [19:0]         hit_ppn;
  logic [1:0]          hit_perms;
  logic [LRU_BITS-1:0] hit_cnt;
  logic                hit_ok;
  logic [WAY_BITS-1:0] victim_way;
  logic                accept;

`ifdef TLB_FLUSH_EN
  localparam int FC_W = SET_INDEX_BITS + WAY_BITS;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(NUM_SETS * NUM_WAYS - 1);
  logic [FC_W-1:0] flush_cnt;
`endif

  assign vpn = vaddr_q[31:PAGE_OFFSET_BITS];
  assign set = vpn[SET_INDEX_BITS-1:0] & SET_INDEX_BITS'(NUM_SETS - 1);

  // descending scan so the lowest matching way wins
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    hit_ppn   = '0;
    hit_perms = '0;
    hit_cnt   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (rd_valid[w] && rd_vpn[w*20 +: 20] == vpn) begin
        hit       = 1'b1;
        hit_way   = WAY_BITS'(w);
        hit_ppn   = rd_ppn[w*20 +: 20];
        hit_perms = rd_perms[w*2 +: 2];
        hit_cnt   = rd_lru_count[w*LRU_BITS +: LRU_BITS];
      end
    end
  end

  assign hit_ok = perm_ok(hit_perms, write_q);

  tlb_victim_sel #(
    .NUM_WAYS (NUM_WAYS),
    .LRU_BITS (LRU_BITS)
  ) u_victim (
    .valid     (rd_valid),
    .lru_count (rd_lru_count),
    .victim    (victim_way)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_paddr     = '0;
    resp_hit       = 1'b0;
    resp_fault     = 1'b0;
    walk_req_valid = 1'b0;
    walk_vpn       = '0;
    rd_set_index   = set;
    wr_en          = 1'b0;
    wr_set_index   = '0;
    wr_way         = '0;
    wr_valid       = 1'b0;
    wr_vpn         = '0;
    wr_ppn         = '0;
    wr_perms       = '0;
    wr_lru_count   = '0;
    lru_update_en  = 1'b0;
    lru_set_index  = '0;
    lru_way        = '0;
    lru_value      = '0;
`ifdef TLB_FLUSH_EN
    flush_busy     = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
`ifdef TLB_FLUSH_EN
        if (flush_req) begin
          req_ready = 1'b0;
          state_nxt = S_FLUSH;
        end else
`endif
        if (req_valid) state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit) begin
          if (hit_ok && !(&hit_cnt)) begin
            lru_update_en = 1'b1;
            lru_set_index = set;
            lru_way       = hit_way;
            lru_value     = hit_cnt + 1'b1;
          end
          state_nxt = S_RESP;
        end else begin
          state_nxt = S_WALK_REQ;
        end
      end
      S_WALK_REQ: begin
        walk_req_valid = 1'b1;
        walk_vpn       = vpn;
        if (walk_req_ready) state_nxt = S_WALK_WAIT;
      end
      S_WALK_WAIT: begin
        if (walk_resp_valid)
          state_nxt = walk_fault ? S_RESP : S_FILL;
      end
      S_FILL: begin
        wr_en        = 1'b1;
        wr_set_index = set;
        wr_way       = way_q;
        wr_valid     = 1'b1;
        wr_vpn       = vpn;
        wr_ppn       = ppn_q;
        wr_perms     = perms_q;
        wr_lru_count = LRU_BITS'(1);
        state_nxt    = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_hit   = hit_q;
        resp_fault = fault_q;
        if (!fault_q)
          resp_paddr = {ppn_q, vaddr_q[PAGE_OFFSET_BITS-1:0]};
        if (resp_ready) state_nxt = S_IDLE;
      end
`ifdef TLB_FLUSH_EN
      S_FLUSH: begin
        flush_busy   = 1'b1;
        wr_en        = 1'b1;
        wr_set_index = flush_cnt[FC_W-1:WAY_BITS];
        wr_way       = flush_cnt[WAY_BITS-1:0];
        if (flush_cnt == FC_LAST) state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept = (state == S_IDLE) && req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vaddr_q   <= '0;
      write_q   <= 1'b0;
      ppn_q     <= '0;
      perms_q   <= '0;
      hit_q     <= 1'b0;
      fault_q   <= 1'b0;
      way_q     <= '0;
`ifdef TLB_FLUSH_EN
      flush_cnt <= '0;
`endif
    end else begin
      if (accept) begin
        vaddr_q <= req_vaddr;
        write_q <= req_write;
        hit_q   <= 1'b0;
        fault_q <= 1'b0;
        ppn_q   <= '0;
      end
      if (state == S_LOOKUP) begin
        if (hit) begin
          hit_q   <= 1'b1;
          ppn_q   <= hit_ppn;
          fault_q <= !hit_ok;
        end else begin
          way_q   <= victim_way;
        end
      end
      if (state == S_WALK_WAIT && walk_resp_valid) begin
        if (walk_fault) begin
          fault_q <= 1'b1;
        end else begin
          ppn_q   <= walk_ppn;
          perms_q <= walk_perms;
        end
      end
      if (state == S_FILL)
        fault_q <= !perm_ok(perms_q, write_q);
`ifdef TLB_FLUSH_EN
      if (state == S_FLUSH) flush_cnt <= flush_cnt + 1'b1;
      else                  flush_cnt <= '0;
`endif
    end
  end

endmodule
